// File: rtl/onehot_encoder_8_3.sv
// Sequential 8-to-3 encoder: accepts a multi-hot request vector and emits the
// index of each set bit, one per output handshake, in fixed priority order.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no vector pending, ready to accept one
// ST_EMIT   | presenting the next pending index on out_idx
module onehot_encoder_8_3 #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic [2:0] out_seq
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_pending;
    logic [2:0] r_seq;

    logic [2:0] w_idx;
    logic       w_single;
    logic       w_emit;
    logic       w_out_hs;
    logic       w_in_hs;
    logic       w_in_nonzero;

    // Later loop iterations override earlier ones, so the iteration order picks the winner.
    always_comb begin
        w_idx = 3'd0;
        if (LSB_FIRST != 0) begin
            for (int i = 7; i >= 0; i--) begin
                if (r_pending[i]) w_idx = 3'(i);
            end
        end else begin
            for (int i = 0; i <= 7; i++) begin
                if (r_pending[i]) w_idx = 3'(i);
            end
        end
    end

    assign w_single     = (r_pending != 8'd0) && ((r_pending & (r_pending - 8'd1)) == 8'd0);
    assign w_emit       = (r_state == ST_EMIT);
    assign w_out_hs     = w_emit & out_ready;
    assign w_in_nonzero = (in_vec != 8'd0);

    assign out_valid = w_emit;
    assign out_idx   = w_emit ? w_idx   : 3'd0;
    assign out_last  = w_emit ? w_single : 1'b0;
    assign out_seq   = w_emit ? r_seq   : 3'd0;

    assign in_ready = ~rst & (~w_emit | (w_out_hs & w_single));
    assign w_in_hs  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 8'd0;
            r_seq     <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_hs && w_in_nonzero) begin
                        r_pending <= in_vec;
                        r_seq     <= 3'd0;
                        r_state   <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_out_hs) begin
                        if (w_single) begin
                            if (w_in_hs && w_in_nonzero) begin
                                r_pending <= in_vec;
                                r_seq     <= 3'd0;
                            end else begin
                                r_pending <= 8'd0;
                                r_seq     <= 3'd0;
                                r_state   <= ST_IDLE;
                            end
                        end else begin
                            r_pending <= r_pending & ~(8'd1 << w_idx);
                            r_seq     <= r_seq + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pending <= 8'd0;
                    r_seq     <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_encoder_8_3.sv
// Directed bench for onehot_encoder_8_3: an ascending and a descending instance
// share all inputs, so every vector is checked in both priority orders.
module tb_onehot_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       l_in_ready, l_out_valid, l_out_last;
    logic [2:0] l_out_idx, l_out_seq;
    logic       m_in_ready, m_out_valid, m_out_last;
    logic [2:0] m_out_idx, m_out_seq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    onehot_encoder_8_3 #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_vec(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_idx(l_out_idx), .out_last(l_out_last), .out_seq(l_out_seq)
    );

    onehot_encoder_8_3 #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_vec(in_vec), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_idx(m_out_idx), .out_last(m_out_last), .out_seq(m_out_seq)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, " l_valid"}, int'(l_out_valid), 0);
        chk({tag, " m_valid"}, int'(m_out_valid), 0);
        chk({tag, " l_idx"}, int'(l_out_idx), 0);
        chk({tag, " l_seq"}, int'(l_out_seq), 0);
        chk({tag, " l_last"}, int'(l_out_last), 0);
    endtask

    task automatic send(input string tag, input logic [7:0] vec);
        in_valid = 1'b1;
        in_vec   = vec;
        #1;
        chk({tag, " l_in_ready"}, int'(l_in_ready), 1);
        chk({tag, " m_in_ready"}, int'(m_in_ready), 1);
        step();
        in_valid = 1'b0;
        in_vec   = 8'h5A;
    endtask

    // Checks one output beat with out_ready high, then takes it.
    task automatic beat(input string tag, input int lidx, input int midx,
                        input int seq, input int last);
        #1;
        chk({tag, " l_valid"}, int'(l_out_valid), 1);
        chk({tag, " l_idx"}, int'(l_out_idx), lidx);
        chk({tag, " m_idx"}, int'(m_out_idx), midx);
        chk({tag, " l_seq"}, int'(l_out_seq), seq);
        chk({tag, " m_seq"}, int'(m_out_seq), seq);
        chk({tag, " l_last"}, int'(l_out_last), last);
        chk({tag, " m_last"}, int'(m_out_last), last);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 8'hFF;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("rst out_valid", int'(l_out_valid), 0);
            chk("rst in_ready", int'(l_in_ready), 0);
            chk("rst m_in_ready", int'(m_in_ready), 0);
            chk("rst out_idx", int'(l_out_idx), 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post-rst in_ready", int'(l_in_ready), 1);
        chk_idle("post-rst");

        send("a6", 8'hA6);
        beat("a6 b0", 1, 7, 0, 0);
        beat("a6 b1", 2, 5, 1, 0);
        beat("a6 b2", 5, 2, 2, 0);
        beat("a6 b3", 7, 1, 3, 1);
        chk_idle("a6 done");

        send("ff", 8'hFF);
        for (int i = 0; i < 8; i++) beat("ff", i, 7 - i, i, (i == 7) ? 1 : 0);
        chk_idle("ff done");

        send("80", 8'h80);
        beat("80", 7, 7, 0, 1);
        chk_idle("80 done");

        in_valid = 1'b1;
        in_vec   = 8'h00;
        #1;
        chk("00 in_ready", int'(l_in_ready), 1);
        step();
        in_valid = 1'b0;
        chk_idle("00 dropped");
        chk("00 in_ready after", int'(l_in_ready), 1);

        send("11", 8'h11);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp valid", int'(l_out_valid), 1);
            chk("bp l_idx", int'(l_out_idx), 0);
            chk("bp m_idx", int'(m_out_idx), 4);
            chk("bp seq", int'(l_out_seq), 0);
            chk("bp last", int'(l_out_last), 0);
            chk("bp in_ready", int'(l_in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        beat("11 b0", 0, 4, 0, 0);
        beat("11 b1", 4, 0, 1, 1);
        chk_idle("11 done");

        in_valid = 1'b1;
        in_vec   = 8'h03;
        #1;
        chk("b2b in_ready0", int'(l_in_ready), 1);
        step();
        in_vec = 8'h40;
        #1;
        chk("b2b in_ready1", int'(l_in_ready), 0);
        beat("b2b c1", 0, 1, 0, 0);
        #1;
        chk("b2b in_ready2", int'(l_in_ready), 1);
        chk("b2b m_in_ready2", int'(m_in_ready), 1);
        beat("b2b c2", 1, 0, 1, 1);
        in_valid = 1'b0;
        in_vec   = 8'h00;
        beat("b2b c3", 6, 6, 0, 1);
        chk_idle("b2b done");

        send("f0", 8'hF0);
        beat("f0 b0", 4, 7, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst in_ready", int'(l_in_ready), 0);
        step();
        rst = 1'b0;
        chk_idle("midrst");
        send("01", 8'h01);
        beat("01", 0, 0, 0, 1);
        chk_idle("01 done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_8_3.md
# onehot_encoder_8_3

Sequential 8-to-3 encoder: the inverse of the 3-to-8 decoder. It accepts an 8-bit request vector over a valid/ready handshake and emits the 3-bit index of every set bit, one index per handshake, in fixed priority order. Typical uses are serialising a multi-hot enable/status vector into indices for the datapath, or encoding the one-hot output of a decoder back to binary.

## Interface
Parameters:
- `LSB_FIRST`, default 1: 1 emits indices ascending (bit 0 first); 0 emits descending (bit 7 first).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_vec` is offered.
- `in_ready`  out  1  block can accept a vector this cycle.
- `in_vec`  in  8  request vector; sampled only on the input handshake.
- `out_valid`  out  1  `out_idx` is valid.
- `out_ready`  in  1  consumer takes `out_idx` this cycle.
- `out_idx`  out  3  binary index of the current highest-priority pending bit.
- `out_last`  out  1  current index is the final one for this vector.
- `out_seq`  out  3  0-based ordinal of the current index within its vector.

## Operation
- Internal state: `pending[7:0]`, `seq[2:0]`, FSM {IDLE, EMIT}.
- Input handshake: `in_valid & in_ready` at a rising edge.
- Output handshake: `out_valid & out_ready` at a rising edge.
- IDLE:
  - `in_ready` = 1 and `out_valid` = 0.
  - On an input handshake with `in_vec` != 0: `pending` <= `in_vec`, `seq` <= 0, go to EMIT.
  - On an input handshake with `in_vec` = 0: the vector is consumed and dropped. No output is produced and the FSM stays in IDLE.
- EMIT:
  - `out_valid` = 1.
  - `out_idx` = priority encode of `pending`: lowest set bit if `LSB_FIRST`=1, else highest set bit.
  - `out_last` = 1 iff `pending` has exactly one bit set.
  - `out_seq` = `seq`.
- On an output handshake:
  - Clear bit `out_idx` of `pending` and increment `seq`.
  - If `out_last`, go to IDLE.
- Back-to-back vectors:
  - `in_ready` = IDLE | (EMIT & `out_valid` & `out_ready` & `out_last`).
  - When the last output handshake and an input handshake occur in the same cycle, the new vector loads directly: `pending` <= `in_vec`, `seq` <= 0, and the FSM stays in EMIT.
  - If that new vector is 0, the FSM goes to IDLE instead.
- Outputs are functions of registered state only, except `in_ready`, which has a combinational path from `out_ready`.
- Outputs are stable while `out_valid` = 1 and `out_ready` = 0.
- `in_vec` is ignored outside the input handshake.
- When `out_valid` = 0, `out_idx`, `out_last` and `out_seq` read 0.
- `seq` never exceeds 7 (at most 8 bits set).

## Timing
- Reset values while `rst` = 1 at a clock edge:
  - FSM = IDLE, `pending` = 0, `seq` = 0.
  - `out_valid` = 0, `out_idx` = 0, `out_last` = 0, `out_seq` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` is deasserted.
- Reset mid-vector: remaining indices are discarded, and no output handshake completes on the reset edge.
- Latency: for a vector accepted at edge N, the first index has `out_valid` = 1 in the cycle after edge N.
- Throughput:
  - One index per cycle while `out_ready` = 1.
  - A vector with k bits set occupies exactly k output cycles.
  - Zero idle cycles between vectors when the input is presented on the last-index cycle.
- Backpressure: `out_ready` = 0 holds all outputs and state. There is no timeout.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid` = 1 -> `out_valid` = 0 and `in_ready` = 0 throughout. The first cycle after release has `in_ready` = 1, and no vector was accepted during reset.
- Priority order, `out_ready` = 1:
  - `LSB_FIRST`=1, `in_vec` = 8'b1010_0110 -> `out_idx` 1, 2, 5, 7 on consecutive cycles, `out_seq` 0..3, `out_last` only on 7.
  - `LSB_FIRST`=0, same vector -> 7, 5, 2, 1.
- Extremes:
  - 8'hFF -> indices 0..7 in 8 cycles, `out_seq` 7 on the last.
  - 8'h80 -> single beat with `out_idx` = 7 and `out_last` = 1.
  - 8'h00 -> accepted, no `out_valid`, `in_ready` stays 1.
- Backpressure: 8'b0001_0001 with `out_ready` low for 4 cycles at the first index -> `out_idx` = 0 held stable. Release -> 0 then 4.
- Back-to-back: vector 8'h03 then 8'h40 offered continuously -> indices 0, 1, 6 on three consecutive cycles, with `in_ready` = 1 on the cycle `out_idx` = 1 is handshaked.
- Reset mid-vector: 8'hF0, assert `rst` after index 4 is taken -> next cycle `out_valid` = 0. A new vector 8'h01 after release yields a single index 0 with `out_seq` = 0.
